// File: rtl/rst_gen_pkg.sv
// rst_gen_pkg: shared state encoding, counter sizing and synchronizer depth for the reset sequencer
package rst_gen_pkg;

    typedef enum logic [1:0] {HOLD, RELEASE, DONE} state_e;

    localparam int SYNC_DEPTH = 2;

    function automatic int cnt_width(input int hold_c, input int gap_c, input int db_c);
        int m;
        m = hold_c > gap_c ? hold_c : gap_c;
        m = db_c > m ? db_c : m;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_debounce.sv
// rst_debounce: passes din to dout only after din has differed from dout for DB_CYCLES consecutive cycles
module rst_debounce
    import rst_gen_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = cnt_width(1, 1, DB_CYCLES);
    localparam logic [CW-1:0] DB_END = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;

    // Count consecutive cycles of disagreement; any agreement or a flip restarts the count
    always_comb begin
        cnt_d  = (din == dout_q || cnt_q == DB_END) ? '0 : cnt_q + 1'b1;
        dout_d = (din != dout_q && cnt_q == DB_END) ? din : dout_q;
    end

    // Register the stable-time counter and the filtered level; reset means no request
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/rst_seq_gen.sv
// rst_seq_gen: merges reset requests, holds all channels, then releases them in order; RST_DEBOUNCE_EN adds a pushbutton debouncer
module rst_seq_gen
    import rst_gen_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int HOLD_CYCLES    = 1000,
    parameter int GAP_CYCLES     = 16,
    parameter bit EXT_ACTIVE_LOW = 1'b1,
    parameter int DB_CYCLES      = 500000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ext_rst_req,
    input  logic            sw_rst_req,
    output logic [N_CH-1:0] rst_out,
    output logic            rst_done,
    output logic            busy
);

    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES, DB_CYCLES);
    localparam int IW = $clog2(N_CH + 1);
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST     = IW'(N_CH - 1);
    localparam logic          IDLE_LVL = EXT_ACTIVE_LOW;

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  ext_raw, ext_req, req;
    logic                  rst_dly_q;
    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [N_CH-1:0]       rst_out_q, rst_out_d;
    logic                  rst_done_q, rst_done_d;
    logic                  busy_q, busy_d;

    // Bring the pushbutton into the clock domain, parked at its inactive level on reset
    always_ff @(posedge clk) begin
        if (rst) sync_q <= {SYNC_DEPTH{IDLE_LVL}};
        else     sync_q <= {sync_q[SYNC_DEPTH-2:0], ext_rst_req};
    end

    assign ext_raw = sync_q[SYNC_DEPTH-1] ^ IDLE_LVL;

`ifdef RST_DEBOUNCE_EN
    rst_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (ext_raw),
        .dout (ext_req)
    );
`else
    assign ext_req = ext_raw;
`endif

    // The edge right after rst drops still behaves as reset, so counting starts one edge later
    assign req = rst_dly_q | ext_req | sw_rst_req;

    // Sequencer: any request restarts the hold; otherwise count the hold, then peel channels off from bit 0
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rst_out_d  = rst_out_q;
        rst_done_d = rst_done_q;
        if (req) begin
            state_d    = HOLD;
            cnt_d      = '0;
            idx_d      = '0;
            rst_out_d  = '1;
            rst_done_d = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    cnt_d = (cnt_q == HOLD_END) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == HOLD_END) begin
                        rst_out_d  = rst_out_q << 1;
                        rst_done_d = (N_CH == 1);
                        state_d    = (N_CH == 1) ? DONE : RELEASE;
                    end
                end
                RELEASE: begin
                    cnt_d = (cnt_q == GAP_END) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == GAP_END) begin
                        idx_d      = idx_q + 1'b1;
                        rst_out_d  = rst_out_q << 1;
                        rst_done_d = (idx_d == LAST);
                        state_d    = (idx_d == LAST) ? DONE : RELEASE;
                    end
                end
                default: ;
            endcase
        end
        busy_d = ~rst_done_d;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_dly_q  <= 1'b1;
            state_q    <= HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            rst_out_q  <= '1;
            rst_done_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            rst_dly_q  <= 1'b0;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rst_out_q  <= rst_out_d;
            rst_done_q <= rst_done_d;
            busy_q     <= busy_d;
        end
    end

    assign rst_out  = rst_out_q;
    assign rst_done = rst_done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// tb_rst_seq_gen: directed plus random requests checked every cycle against a release-schedule model
module tb_rst_seq_gen;

    localparam int N_CH    = 4;
    localparam int HOLD    = 10;
    localparam int GAP     = 3;
    localparam int DB      = 8;
    localparam bit ACT_LOW = 1'b1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ext_rst_req = ACT_LOW;
    logic            sw_rst_req = 1'b0;
    logic [N_CH-1:0] rst_out;
    logic            rst_done;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    rst_seq_gen #(
        .N_CH           (N_CH),
        .HOLD_CYCLES    (HOLD),
        .GAP_CYCLES     (GAP),
        .EXT_ACTIVE_LOW (ACT_LOW),
        .DB_CYCLES      (DB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ext_rst_req (ext_rst_req),
        .sw_rst_req  (sw_rst_req),
        .rst_out     (rst_out),
        .rst_done    (rst_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: the sequence is a pure function of the edges elapsed since the last request
    int              t = 0;
    int              last_req = 0;
    int              k;
    bit              rst_prev = 1'b1;
    bit              raw, din, ext_req, req, all_diff;
    bit              sync_hist[$];
    bit              din_hist[$];
    bit              deb = 1'b0;
    logic [N_CH-1:0] ones = '1;
    logic [N_CH-1:0] exp_out;

    always @(posedge clk) begin
        raw = ACT_LOW ? !ext_rst_req : ext_rst_req;
        din = (sync_hist.size() >= 2) ? sync_hist[sync_hist.size()-2] : 1'b0;
        sync_hist.push_back(rst ? 1'b0 : raw);
        if (sync_hist.size() > 4) void'(sync_hist.pop_front());
`ifdef RST_DEBOUNCE_EN
        ext_req = deb;
        din_hist.push_back(din);
        if (din_hist.size() > DB) void'(din_hist.pop_front());
        all_diff = (din_hist.size() == DB);
        foreach (din_hist[i]) if (din_hist[i] == deb) all_diff = 1'b0;
        if (all_diff) begin
            deb = !deb;
            din_hist.delete();
        end
        if (rst) begin
            deb = 1'b0;
            din_hist.delete();
        end
`else
        ext_req = din;
`endif
        req = rst || rst_prev || ext_req || sw_rst_req;
        rst_prev = rst;
        if (req) last_req = t;
        k = (t - last_req < HOLD) ? 0 : (t - last_req - HOLD) / GAP + 1;
        if (k > N_CH) k = N_CH;
        exp_out = ones << k;
        t++;
        #1;
        chk("rst_out", 32'(rst_out), 32'(exp_out));
        chk("rst_done", 32'(rst_done), 32'(k == N_CH));
        chk("busy", 32'(busy), 32'(k != N_CH));
    end

    task automatic pulse_sw();
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
    endtask

    task automatic ext_low(input int n);
        ext_rst_req = !ACT_LOW;
        repeat (n) @(negedge clk);
        ext_rst_req = ACT_LOW;
    endtask

    initial begin
        int r;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        pulse_sw();
        repeat (30) @(negedge clk);
        pulse_sw();
        repeat (12) @(negedge clk);
        pulse_sw();
        repeat (30) @(negedge clk);
        ext_low(1);
        repeat (40) @(negedge clk);
        ext_low(5);
        repeat (40) @(negedge clk);
        ext_low(20);
        repeat (50) @(negedge clk);
        pulse_sw();
        repeat (14) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 199);
            if (r < 3) pulse_sw();
            else if (r < 6) ext_low($urandom_range(1, 25));
            else if (r == 6) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end else @(negedge clk);
        end
        repeat (60) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
